// File: rtl/ex_mem_seg_reg.sv
// ============================================================================
//  Module      : ex_mem_seg_reg
//  Description : EX/MEM pipeline segment register. Captures the ALU result,
//                the store data and the control fields for the MEM stage. It
//                also lane-aligns store data, generates byte write enables and
//                flags misaligned loads and stores from the EX-side address.
//                Supports stall (hold) and flush (bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_seg_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clear,
  input  logic [XLEN-1:0] AluOut_EX,
  input  logic [XLEN-1:0] StoreData_EX,
  input  logic [1:0]      MemWrite_EX,
  input  logic [2:0]      LoadNPC_EX,
  input  logic            MemToReg_EX,
  input  logic            RegWrite_EX,
  input  logic [4:0]      rd_EX,
  input  logic [XLEN-1:0] PC_EX,
  output logic [XLEN-1:0] AluOut_MEM,
  output logic [XLEN-1:0] StoreData_MEM,
  output logic [3:0]      ByteWe_MEM,
  output logic [2:0]      LoadNPC_MEM,
  output logic            MemToReg_MEM,
  output logic            RegWrite_MEM,
  output logic [4:0]      rd_MEM,
  output logic [XLEN-1:0] PC_MEM,
  output logic            Valid_MEM,
  output logic            MisalignErr_MEM
);

  // Store size encodings
  localparam logic [1:0] c_ST_NONE = 2'b00;
  localparam logic [1:0] c_ST_BYTE = 2'b01;
  localparam logic [1:0] c_ST_HALF = 2'b10;
  localparam logic [1:0] c_ST_WORD = 2'b11;

  // Load type codes that carry an alignment requirement
  localparam logic [2:0] c_LD_LH  = 3'd2;
  localparam logic [2:0] c_LD_LW  = 3'd3;
  localparam logic [2:0] c_LD_LHU = 3'd5;

  // Pipeline state
  logic [XLEN-1:0] alu_q,  alu_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [3:0]      we_q,   we_d;
  logic [2:0]      lnpc_q, lnpc_d;
  logic            m2r_q,  m2r_d;
  logic            rw_q,   rw_d;
  logic [4:0]      rd_q,   rd_d;
  logic [XLEN-1:0] pc_q,   pc_d;
  logic            vld_q,  vld_d;
  logic            mis_q,  mis_d;

  // Alignment helpers
  logic [1:0] w_a;
  logic       w_st_mis;
  logic       w_ld_mis;

  // Lane alignment, byte enables and misalignment detection on the EX address
  always_comb begin
    w_a      = AluOut_EX[1:0];
    w_st_mis = 1'b0;
    w_ld_mis = 1'b0;
    sdata_d  = StoreData_EX;
    we_d     = 4'b0000;

    unique case (MemWrite_EX)
      c_ST_BYTE: begin
        sdata_d = {4{StoreData_EX[7:0]}};
        we_d    = 4'b0001 << w_a;
      end
      c_ST_HALF: begin
        sdata_d = {2{StoreData_EX[15:0]}};
        if (w_a[0]) begin
          w_st_mis = 1'b1;
        end else begin
          we_d = w_a[1] ? 4'b1100 : 4'b0011;
        end
      end
      c_ST_WORD: begin
        sdata_d = StoreData_EX;
        if (w_a != 2'b00) begin
          w_st_mis = 1'b1;
        end else begin
          we_d = 4'b1111;
        end
      end
      default: begin
        sdata_d = StoreData_EX;
        we_d    = 4'b0000;
      end
    endcase

    // Load alignment only matters for a genuine load (no concurrent store)
    if (MemToReg_EX && (MemWrite_EX == c_ST_NONE)) begin
      if (((LoadNPC_EX == c_LD_LH) || (LoadNPC_EX == c_LD_LHU)) && w_a[0]) begin
        w_ld_mis = 1'b1;
      end else if ((LoadNPC_EX == c_LD_LW) && (w_a != 2'b00)) begin
        w_ld_mis = 1'b1;
      end
    end

    alu_d  = AluOut_EX;
    lnpc_d = LoadNPC_EX;
    m2r_d  = MemToReg_EX;
    // A faulting load must never write back to rd
    rw_d   = RegWrite_EX & ~w_ld_mis;
    rd_d   = rd_EX;
    pc_d   = PC_EX;
    vld_d  = 1'b1;
    mis_d  = w_st_mis | w_ld_mis;
  end

  // Segment register: reset/flush load a bubble, en captures, otherwise hold
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      alu_q   <= '0;
      sdata_q <= '0;
      we_q    <= 4'b0000;
      lnpc_q  <= 3'd0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= 5'd0;
      pc_q    <= '0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (en) begin
      alu_q   <= alu_d;
      sdata_q <= sdata_d;
      we_q    <= we_d;
      lnpc_q  <= lnpc_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign AluOut_MEM      = alu_q;
  assign StoreData_MEM   = sdata_q;
  assign ByteWe_MEM      = we_q;
  assign LoadNPC_MEM     = lnpc_q;
  assign MemToReg_MEM    = m2r_q;
  assign RegWrite_MEM    = rw_q;
  assign rd_MEM          = rd_q;
  assign PC_MEM          = pc_q;
  assign Valid_MEM       = vld_q;
  assign MisalignErr_MEM = mis_q;

endmodule

`default_nettype wire
